// File: rtl/hdu_mc.sv
// Hazard detection unit with multi-cycle load-use stall, stall-and-hold for iterative EX ops,
// and a saturating stall-cycle counter. Drives all pipeline-register enables and clears.
module hdu_mc #(
   parameter int unsigned REG_AW    = 5,
   parameter int unsigned LU_CYCLES = 1,
   parameter int unsigned CNT_W     = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              br_flush_i,
   input  logic              IDEX_rdwren_i,
   input  logic              IDEX_mem_rden_i,
   input  logic              IDEX_mc_i,
   input  logic [REG_AW-1:0] IDEX_rd_i,
   input  logic [REG_AW-1:0] IFID_rs1_i,
   input  logic [REG_AW-1:0] IFID_rs2_i,
   input  logic              IFID_rs1_en_i,
   input  logic              IFID_rs2_en_i,
   input  logic              mc_done_i,
   input  logic              perf_clr_i,
   output logic              IFID_clear_o,
   output logic              IDEX_clear_o,
   output logic              EXMEM_clear_o,
   output logic              IFID_wren_o,
   output logic              IDEX_wren_o,
   output logic              pc_wren_o,
   output logic              mc_start_o,
   output logic              mc_kill_o,
   output logic              mc_busy_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   typedef enum logic [1:0] {StIdle, StLuStall, StMcBusy} state_e;

   localparam logic [2:0] LuInit = 3'(LU_CYCLES - 1);

   state_e           state_q, state_d;
   logic [2:0]       lu_cnt_q, lu_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             lu_hit;
   logic             ifid_clr, idex_clr, exmem_clr;
   logic             ifid_wr, idex_wr, pc_wr;
   logic             start, kill;

   assign lu_hit = IDEX_mem_rden_i & IDEX_rdwren_i & (IDEX_rd_i != '0) &
                   ((IFID_rs1_en_i & (IFID_rs1_i == IDEX_rd_i)) |
                    (IFID_rs2_en_i & (IFID_rs2_i == IDEX_rd_i)));

   always_comb begin
      state_d   = state_q;
      lu_cnt_d  = lu_cnt_q;
      ifid_clr  = 1'b0;
      idex_clr  = 1'b0;
      exmem_clr = 1'b0;
      ifid_wr   = 1'b1;
      idex_wr   = 1'b1;
      pc_wr     = 1'b1;
      start     = 1'b0;
      kill      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (br_flush_i) begin
               ifid_clr  = 1'b1;
               idex_clr  = 1'b1;
               exmem_clr = 1'b1;
            end else if (IDEX_mc_i) begin
               start     = 1'b1;
               pc_wr     = 1'b0;
               ifid_wr   = 1'b0;
               idex_wr   = 1'b0;
               exmem_clr = 1'b1;
               state_d   = StMcBusy;
            end else if (lu_hit) begin
               idex_clr = 1'b1;
               pc_wr    = 1'b0;
               ifid_wr  = 1'b0;
               if (LU_CYCLES > 1) begin
                  lu_cnt_d = LuInit;
                  state_d  = StLuStall;
               end
            end
         end
         StLuStall: begin
            if (br_flush_i) begin
               ifid_clr  = 1'b1;
               idex_clr  = 1'b1;
               exmem_clr = 1'b1;
               lu_cnt_d  = '0;
               state_d   = StIdle;
            end else begin
               // Hazard is not re-checked; the bubble count was fixed on entry.
               idex_clr = 1'b1;
               pc_wr    = 1'b0;
               ifid_wr  = 1'b0;
               lu_cnt_d = lu_cnt_q - 3'd1;
               if (lu_cnt_q == 3'd1) state_d = StIdle;
            end
         end
         StMcBusy: begin
            if (br_flush_i) begin
               ifid_clr  = 1'b1;
               idex_clr  = 1'b1;
               exmem_clr = 1'b1;
               kill      = 1'b1;
               state_d   = StIdle;
            end else if (mc_done_i) begin
               state_d = StIdle;
            end else begin
               pc_wr     = 1'b0;
               ifid_wr   = 1'b0;
               idex_wr   = 1'b0;
               exmem_clr = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs fall back to pass-through defaults while reset is held.
   assign IFID_clear_o  = rst_ni & ifid_clr;
   assign IDEX_clear_o  = rst_ni & idex_clr;
   assign EXMEM_clear_o = rst_ni & exmem_clr;
   assign IFID_wren_o   = ~rst_ni | ifid_wr;
   assign IDEX_wren_o   = ~rst_ni | idex_wr;
   assign pc_wren_o     = ~rst_ni | pc_wr;
   assign mc_start_o    = rst_ni & start;
   assign mc_kill_o     = rst_ni & kill;
   assign mc_busy_o     = rst_ni & (state_q == StMcBusy);
   assign stall_cnt_o   = stall_cnt_q;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (perf_clr_i) begin
         stall_cnt_d = '0;
      end else if (!pc_wren_o && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         lu_cnt_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         lu_cnt_q    <= lu_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule

// File: tb/tb_hdu_mc.sv
// Scoreboard bench for hdu_mc: two instances (LU_CYCLES=1/CNT_W=32 and LU_CYCLES=3/CNT_W=4)
// share stimulus; a pending-bubble/busy-flag reference model predicts every cycle's outputs.
module tb_hdu_mc;

   typedef struct {
      logic       rst_n, flush, rdwren, rden, mc;
      logic [4:0] rd, rs1, rs2;
      logic       rs1_en, rs2_en, done, pclr;
   } in_t;

   typedef struct {
      bit     ifid_c, idex_c, exmem_c, ifid_w, idex_w, pc_w, start, kill, busy;
      longint cnt;
   } exp_t;

   logic clk = 1'b0;
   in_t  cur;

   logic a_ifc, a_idc, a_exc, a_ifw, a_idw, a_pcw, a_st, a_kl, a_bz;
   logic b_ifc, b_idc, b_exc, b_ifw, b_idw, b_pcw, b_st, b_kl, b_bz;
   logic [31:0] a_cnt;
   logic [3:0]  b_cnt;

   exp_t q_a[$];
   exp_t q_b[$];

   int     lu_left[2];
   bit     mc_on[2];
   longint cnt[2];
   int     lu_p[2]  = '{1, 3};
   longint cmax[2]  = '{64'hFFFF_FFFF, 15};

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   hdu_mc #(.REG_AW(5), .LU_CYCLES(1), .CNT_W(32)) dut_a (
      .clk_i(clk), .rst_ni(cur.rst_n), .br_flush_i(cur.flush),
      .IDEX_rdwren_i(cur.rdwren), .IDEX_mem_rden_i(cur.rden), .IDEX_mc_i(cur.mc),
      .IDEX_rd_i(cur.rd), .IFID_rs1_i(cur.rs1), .IFID_rs2_i(cur.rs2),
      .IFID_rs1_en_i(cur.rs1_en), .IFID_rs2_en_i(cur.rs2_en), .mc_done_i(cur.done),
      .perf_clr_i(cur.pclr), .IFID_clear_o(a_ifc), .IDEX_clear_o(a_idc),
      .EXMEM_clear_o(a_exc), .IFID_wren_o(a_ifw), .IDEX_wren_o(a_idw), .pc_wren_o(a_pcw),
      .mc_start_o(a_st), .mc_kill_o(a_kl), .mc_busy_o(a_bz), .stall_cnt_o(a_cnt)
   );

   hdu_mc #(.REG_AW(5), .LU_CYCLES(3), .CNT_W(4)) dut_b (
      .clk_i(clk), .rst_ni(cur.rst_n), .br_flush_i(cur.flush),
      .IDEX_rdwren_i(cur.rdwren), .IDEX_mem_rden_i(cur.rden), .IDEX_mc_i(cur.mc),
      .IDEX_rd_i(cur.rd), .IFID_rs1_i(cur.rs1), .IFID_rs2_i(cur.rs2),
      .IFID_rs1_en_i(cur.rs1_en), .IFID_rs2_en_i(cur.rs2_en), .mc_done_i(cur.done),
      .perf_clr_i(cur.pclr), .IFID_clear_o(b_ifc), .IDEX_clear_o(b_idc),
      .EXMEM_clear_o(b_exc), .IFID_wren_o(b_ifw), .IDEX_wren_o(b_idw), .pc_wren_o(b_pcw),
      .mc_start_o(b_st), .mc_kill_o(b_kl), .mc_busy_o(b_bz), .stall_cnt_o(b_cnt)
   );

   function automatic in_t idle_in();
      in_t v;
      v.rst_n = 1'b1; v.flush = 1'b0; v.rdwren = 1'b0; v.rden = 1'b0; v.mc = 1'b0;
      v.rd = '0; v.rs1 = '0; v.rs2 = '0; v.rs1_en = 1'b0; v.rs2_en = 1'b0;
      v.done = 1'b0; v.pclr = 1'b0;
      return v;
   endfunction

   function automatic in_t rnd_in();
      in_t v;
      v.rst_n  = ($urandom_range(0, 149) != 0);
      v.flush  = ($urandom_range(0, 11) == 0);
      v.rdwren = ($urandom_range(0, 3) != 0);
      v.rden   = $urandom_range(0, 1) == 1;
      v.mc     = ($urandom_range(0, 7) == 0);
      v.rd     = 5'($urandom_range(0, 3));
      v.rs1    = 5'($urandom_range(0, 3));
      v.rs2    = 5'($urandom_range(0, 3));
      v.rs1_en = $urandom_range(0, 1) == 1;
      v.rs2_en = $urandom_range(0, 1) == 1;
      v.done   = ($urandom_range(0, 3) == 0);
      v.pclr   = ($urandom_range(0, 39) == 0);
      return v;
   endfunction

   function automatic logic [8:0] pk(exp_t e);
      return {e.ifid_c, e.idex_c, e.exmem_c, e.ifid_w, e.idex_w, e.pc_w, e.start, e.kill, e.busy};
   endfunction

   // Reference: pending bubbles + "op in EX" flag + counter, from the hazard rules directly.
   task automatic model_eval(input int i, output exp_t e, output int nl, output bit nm,
                             output longint nc);
      bit hit;
      e.ifid_c = 0; e.idex_c = 0; e.exmem_c = 0; e.ifid_w = 1; e.idex_w = 1; e.pc_w = 1;
      e.start = 0; e.kill = 0; e.busy = 0; e.cnt = cnt[i];
      nl = lu_left[i]; nm = mc_on[i]; nc = cnt[i];
      hit = cur.rden && cur.rdwren && (cur.rd != 0) &&
            ((cur.rs1_en && cur.rs1 == cur.rd) || (cur.rs2_en && cur.rs2 == cur.rd));
      if (!cur.rst_n) begin
         e.cnt = 0; nl = 0; nm = 0; nc = 0;
         return;
      end
      if (mc_on[i]) begin
         e.busy = 1;
         if (cur.flush) begin
            e.ifid_c = 1; e.idex_c = 1; e.exmem_c = 1; e.kill = 1; nm = 0;
         end else if (cur.done) begin
            nm = 0;
         end else begin
            e.pc_w = 0; e.ifid_w = 0; e.idex_w = 0; e.exmem_c = 1;
         end
      end else if (lu_left[i] > 0) begin
         if (cur.flush) begin
            e.ifid_c = 1; e.idex_c = 1; e.exmem_c = 1; nl = 0;
         end else begin
            e.idex_c = 1; e.pc_w = 0; e.ifid_w = 0; nl = lu_left[i] - 1;
         end
      end else if (cur.flush) begin
         e.ifid_c = 1; e.idex_c = 1; e.exmem_c = 1;
      end else if (cur.mc) begin
         e.start = 1; e.pc_w = 0; e.ifid_w = 0; e.idex_w = 0; e.exmem_c = 1; nm = 1;
      end else if (hit) begin
         e.idex_c = 1; e.pc_w = 0; e.ifid_w = 0; nl = lu_p[i] - 1;
      end
      if (cur.pclr) nc = 0;
      else if (!e.pc_w && nc < cmax[i]) nc = nc + 1;
   endtask

   task automatic drive(input in_t v);
      exp_t   e;
      int     nl;
      bit     nm;
      longint nc;
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         model_eval(i, e, nl, nm, nc);
         lu_left[i] = nl; mc_on[i] = nm; cnt[i] = nc;
      end
      #1;
      cur = v;
      model_eval(0, e, nl, nm, nc);
      q_a.push_back(e);
      model_eval(1, e, nl, nm, nc);
      q_b.push_back(e);
   endtask

   always @(negedge clk) begin
      exp_t e, a;
      if (q_a.size() > 0) begin
         e = q_a.pop_front();
         a.ifid_c = a_ifc; a.idex_c = a_idc; a.exmem_c = a_exc; a.ifid_w = a_ifw;
         a.idex_w = a_idw; a.pc_w = a_pcw; a.start = a_st; a.kill = a_kl; a.busy = a_bz;
         a.cnt = longint'(a_cnt);
         compared++;
         if (pk(a) !== pk(e) || a.cnt != e.cnt) begin
            mismatched++;
            $display("FAIL dut_a t=%0t outs=%b cnt=%0d expected outs=%b cnt=%0d",
                     $time, pk(a), a.cnt, pk(e), e.cnt);
         end
      end
      if (q_b.size() > 0) begin
         e = q_b.pop_front();
         a.ifid_c = b_ifc; a.idex_c = b_idc; a.exmem_c = b_exc; a.ifid_w = b_ifw;
         a.idex_w = b_idw; a.pc_w = b_pcw; a.start = b_st; a.kill = b_kl; a.busy = b_bz;
         a.cnt = longint'(b_cnt);
         compared++;
         if (pk(a) !== pk(e) || a.cnt != e.cnt) begin
            mismatched++;
            $display("FAIL dut_b t=%0t outs=%b cnt=%0d expected outs=%b cnt=%0d",
                     $time, pk(a), a.cnt, pk(e), e.cnt);
         end
      end
   end

   initial begin
      in_t v;
      cur = idle_in();
      cur.rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         lu_left[i] = 0; mc_on[i] = 0; cnt[i] = 0;
      end
      v = idle_in(); v.rst_n = 1'b0;
      repeat (2) drive(v);

      // Load-use on rs2, then with rs2 not read, then rd=0.
      v = idle_in(); v.rden = 1; v.rdwren = 1; v.rd = 5'd5; v.rs2 = 5'd5; v.rs2_en = 1;
      drive(v);
      repeat (4) drive(idle_in());
      v.rs2_en = 0;
      drive(v);
      repeat (2) drive(idle_in());
      v = idle_in(); v.rden = 1; v.rdwren = 1; v.rd = 5'd0; v.rs1 = 5'd0; v.rs1_en = 1;
      drive(v);
      drive(idle_in());

      // Multi-cycle op with done four cycles after start.
      v = idle_in(); v.mc = 1;
      repeat (4) drive(v);
      v.done = 1;
      drive(v);
      repeat (2) drive(idle_in());

      // Flush and done together two cycles after start.
      v = idle_in(); v.mc = 1;
      repeat (2) drive(v);
      v.flush = 1; v.done = 1;
      drive(v);
      repeat (2) drive(idle_in());

      // Reset in the middle of a load-use stall.
      v = idle_in(); v.rden = 1; v.rdwren = 1; v.rd = 5'd7; v.rs1 = 5'd7; v.rs1_en = 1;
      drive(v);
      v = idle_in(); v.rst_n = 0;
      drive(v);
      repeat (2) drive(idle_in());

      // Long multi-cycle stall drives the 4-bit counter into saturation.
      v = idle_in(); v.mc = 1;
      repeat (21) drive(v);
      v.done = 1;
      drive(v);
      drive(idle_in());

      // Counter clear while stalled.
      v = idle_in(); v.mc = 1;
      repeat (2) drive(v);
      v.pclr = 1;
      drive(v);
      v.pclr = 0; v.done = 1;
      drive(v);
      repeat (2) drive(idle_in());

      for (int n = 0; n < 3000; n++) drive(rnd_in());
      drive(idle_in());
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/hdu_mc.md
# hdu_mc

Parametrised hazard detection unit for the 5-stage core once the iterative multiply/divide unit is added to EX. It adds several behaviours to the combinational load-use/flush logic:
- a configurable multi-cycle load-use stall;
- per-source use qualification;
- a stall-and-hold FSM for multi-cycle EX operations, with start and kill handshakes;
- a saturating stall-cycle performance counter.

It sits beside the ID/EX pipeline register and drives all pipeline-register write enables and clears.

## Interface
- REG_AW, 5: register index width.
- LU_CYCLES, 1: load-use bubbles inserted per detected hazard; legal range 1..7.
- CNT_W, 32: stall counter width.

Ports:
- clk_i  in  1  core clock, all state updates on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- br_flush_i  in  1  branch/jump mispredict resolved in EX
- IDEX_rdwren_i  in  1  instruction in EX writes rd
- IDEX_mem_rden_i  in  1  instruction in EX is a load
- IDEX_mc_i  in  1  instruction in EX is a multi-cycle op (mul/div)
- IDEX_rd_i  in  REG_AW  EX destination register
- IFID_rs1_i, IFID_rs2_i  in  REG_AW  ID source registers
- IFID_rs1_en_i, IFID_rs2_en_i  in  1  ID instruction actually reads rs1/rs2
- mc_done_i  in  1  multi-cycle unit result valid (single-cycle pulse)
- perf_clr_i  in  1  synchronous clear of stall counter
- IFID_clear_o, IDEX_clear_o, EXMEM_clear_o  out  1  insert bubble into that register
- IFID_wren_o, IDEX_wren_o, pc_wren_o  out  1  register/PC update enables
- mc_start_o  out  1  one-cycle start pulse to multi-cycle unit
- mc_kill_o  out  1  one-cycle abort pulse to multi-cycle unit
- mc_busy_o  out  1  FSM in MC_BUSY
- stall_cnt_o  out  CNT_W  cycles with pc_wren_o=0, saturating

## Operation
- FSM states: IDLE, LU_STALL, MC_BUSY. Down-counter lu_cnt is 3 bits wide.
- Default (no-event) outputs: clears=0, wrens=1, pulses=0.
- Load-use hazard (lu_hit) requires all of:
  - IDEX_mem_rden_i & IDEX_rdwren_i & IDEX_rd_i≠0;
  - ((IFID_rs1_en_i & rs1==rd) | (IFID_rs2_en_i & rs2==rd)).
- IDLE, in priority order:
  1. br_flush_i:
     - IFID_clear, IDEX_clear, EXMEM_clear=1; pc/IFID/IDEX wren=1.
     - Stay IDLE.
  2. IDEX_mc_i:
     - mc_start_o=1.
     - pc_wren=IFID_wren=IDEX_wren=0; EXMEM_clear=1.
     - Next state MC_BUSY.
  3. lu_hit:
     - IDEX_clear=1; pc_wren=IFID_wren=0.
     - If LU_CYCLES>1: lu_cnt←LU_CYCLES−1, next state LU_STALL. Otherwise stay IDLE.
  4. Otherwise: defaults.
- LU_STALL:
  - br_flush_i: flush outputs as in IDLE; next state IDLE; lu_cnt←0.
  - Otherwise: IDEX_clear=1, pc_wren=IFID_wren=0; lu_cnt decrements; when lu_cnt==1, next state IDLE. The hazard is not re-evaluated.
- MC_BUSY:
  - br_flush_i: flush outputs plus mc_kill_o=1; next state IDLE.
  - mc_done_i: defaults (IDEX_wren=1, EXMEM_clear=0, so the result enters EX/MEM); next state IDLE.
  - Otherwise: pc_wren=IFID_wren=IDEX_wren=0, EXMEM_clear=1.
- mc_done_i arriving outside MC_BUSY is ignored.
- stall_cnt_o:
  - perf_clr_i: cleared to 0. perf_clr_i wins over increment.
  - Else if pc_wren_o==0: +1, saturating at all-ones.

## Timing
- Reset (rst_ni=0, asynchronous): state=IDLE, lu_cnt=0, stall_cnt_o=0.
- While rst_ni=0, outputs are forced to: all clears=0, all wrens=1, mc_start_o=mc_kill_o=mc_busy_o=0.
- Reset mid-stall or mid-MC_BUSY returns to IDLE immediately; no kill pulse is issued.
- All control outputs are combinational from state and inputs, valid in the same cycle. No added latency.
- Load-use stall length is exactly LU_CYCLES cycles with pc_wren_o=0.
- Multi-cycle stall:
  - mc_start_o asserts in the first cycle the op is in EX.
  - mc_done_i is legal no earlier than the next cycle.
  - Total EX residency is (done cycle − start cycle + 1).
- mc_start_o fires exactly once per mc op. After done, the op leaves ID/EX on that edge, so IDLE never sees the same op again.
- Simultaneous br_flush_i and mc_done_i in MC_BUSY: flush wins and mc_kill_o asserts.
- mc_busy_o is a registered-state decode: high from the cycle after mc_start_o through the mc_done_i/flush cycle inclusive.

## Test plan
- Load-use, LU_CYCLES=1:
  - Stimulus: IDEX load rd=5, rdwren=1, IFID rs2=5, rs2_en=1.
  - Response: one cycle of IDEX_clear=1, pc_wren=0; stall_cnt_o 0→1.
  - Same stimulus with rs2_en=0: no stall.
- LU_CYCLES=3: same hazard → pc_wren_o=0 for exactly 3 cycles with IDEX_clear=1; back to IDLE on the 4th; stall_cnt_o=3.
- rd=0 exclusion: load rd=0 with rs1=0 → no stall.
- Multi-cycle op:
  - Stimulus: IDEX_mc_i=1; mc_done_i pulsed 4 cycles after start.
  - Response: mc_start_o for 1 cycle; mc_busy_o high 4 cycles; pc/IFID/IDEX wren=0 and EXMEM_clear=1 until the done cycle; wrens=1 in the done cycle; stall_cnt_o=4.
- Flush during MC_BUSY:
  - Stimulus: br_flush_i 2 cycles after start, with mc_done_i asserted in the same cycle.
  - Response: mc_kill_o=1; all three clears=1; IDLE next cycle; no second mc_start_o.
- Reset and counter:
  - Assert rst_ni=0 mid-LU_STALL → outputs at defaults immediately; stall_cnt_o=0.
  - With CNT_W=4: 20 stall cycles → stall_cnt_o saturates at 15.
  - perf_clr_i during a stall → counter 0 that cycle.
